// File: rtl/sipo_stream.sv
// Parametrised serial-in/parallel-out deserializer with a one-entry
// valid/ready output register, bit-order select, clear and sticky overrun.
module sipo_stream #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             serial,
    input  logic             clear,
    input  logic             ready,
    output logic [WIDTH-1:0] parallel,
    output logic             valid,
    output logic             overrun,
    output logic [CW-1:0]    bit_count
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] shifted;
    logic             done;

    always_comb begin
        if (LSB_FIRST) begin
            shifted = {serial, sr_q[WIDTH-1:1]};
        end else begin
            shifted = {sr_q[WIDTH-2:0], serial};
        end
    end

    // clear outranks en, so a frame can never complete on a clear edge
    assign done = en && !clear && (cnt_q == LAST);

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (clear) begin
            sr_d  = '0;
            cnt_d = '0;
            ovr_d = 1'b0;
        end else if (en) begin
            sr_d  = shifted;
            cnt_d = done ? '0 : cnt_q + 1'b1;
        end

        if (done) begin
            if (!valid_q || ready) begin
                par_d   = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign parallel  = par_q;
    assign valid     = valid_q;
    assign overrun   = ovr_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_sipo_stream.sv
// Bench for sipo_stream: WIDTH=4 MSB/LSB-first and WIDTH=8 instances
// sharing one input stream, checked by vector tables and a word scoreboard.
module tb_sipo_stream;

    logic clk = 1'b0;
    logic rst, en, serial, clear, ready;

    logic [3:0] p4, p4l;
    logic [7:0] p8;
    logic       v4, v4l, v8;
    logic       o4, o4l, o8;
    logic [1:0] c4, c4l;
    logic [2:0] c8;

    always #5 clk = ~clk;

    sipo_stream #(.WIDTH(4), .LSB_FIRST(1'b0)) u4 (
        .clk(clk), .rst(rst), .en(en), .serial(serial), .clear(clear),
        .ready(ready), .parallel(p4), .valid(v4), .overrun(o4),
        .bit_count(c4)
    );

    sipo_stream #(.WIDTH(4), .LSB_FIRST(1'b1)) u4l (
        .clk(clk), .rst(rst), .en(en), .serial(serial), .clear(clear),
        .ready(ready), .parallel(p4l), .valid(v4l), .overrun(o4l),
        .bit_count(c4l)
    );

    sipo_stream #(.WIDTH(8), .LSB_FIRST(1'b0)) u8 (
        .clk(clk), .rst(rst), .en(en), .serial(serial), .clear(clear),
        .ready(ready), .parallel(p8), .valid(v8), .overrun(o8),
        .bit_count(c8)
    );

    typedef struct {
        logic       en;
        logic       ser;
        logic [1:0] cnt;
        logic       vld;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q4[$];
    logic [7:0] q4l[$];
    logic [7:0] q8[$];
    bit mon4 = 0, mon4l = 0, mon8 = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name, inout logic [7:0] q[$],
                           input int act);
        logic [7:0] e;
        if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got word %0h expected none", name, act);
        end else begin
            e = q.pop_front();
            chk(name, act, int'(e));
        end
    endtask

    // Words are popped at the moment the DUT hands them downstream.
    always @(negedge clk) begin
        if (mon4 && v4 && ready)   pop_chk("sb_u4", q4, int'(p4));
        if (mon4l && v4l && ready) pop_chk("sb_u4l", q4l, int'(p4l));
        if (mon8 && v8 && ready)   pop_chk("sb_u8", q8, int'(p8));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; clear = 1'b0; serial = 1'b0;
        step();
        rst = 1'b1;
        q4.delete(); q4l.delete(); q8.delete();
    endtask

    task automatic send(input logic b);
        en = 1'b1; serial = b; clear = 1'b0;
        step();
    endtask

    vec_t stream_t[40];
    vec_t tog_t[7];

    initial begin
        logic [3:0] pat;
        logic [7:0] byt;
        logic [1:0] tc[7];
        logic       te[7];
        logic       ts[7];

        pat = 4'b1101;
        for (int i = 0; i < 40; i++) begin
            stream_t[i].en  = 1'b1;
            stream_t[i].ser = pat[3 - (i % 4)];
            stream_t[i].cnt = 2'((i + 1) % 4);
            stream_t[i].vld = (i % 4) == 3;
        end
        te = '{1, 0, 0, 1, 1, 0, 1};
        ts = '{1, 0, 1, 1, 0, 1, 1};
        tc = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
        for (int i = 0; i < 7; i++) begin
            tog_t[i].en  = te[i];
            tog_t[i].ser = ts[i];
            tog_t[i].cnt = tc[i];
            tog_t[i].vld = (i == 6);
        end

        // reset state
        ready = 1'b1;
        do_reset();
        chk("rst_valid4", int'(v4), 0);
        chk("rst_par4", int'(p4), 0);
        chk("rst_cnt4", int'(c4), 0);
        chk("rst_ovr4", int'(o4), 0);
        chk("rst_valid8", int'(v8), 0);
        chk("rst_par8", int'(p8), 0);

        // 10 frames of 1,1,0,1 on both bit orders
        mon4 = 1; mon4l = 1;
        for (int i = 0; i < 40; i++) begin
            en = stream_t[i].en;
            serial = stream_t[i].ser;
            clear = 1'b0;
            if (i % 4 == 3) begin
                q4.push_back(8'h0D);
                q4l.push_back(8'h0B);
            end
            step();
            chk("strm_cnt4", int'(c4), int'(stream_t[i].cnt));
            chk("strm_vld4", int'(v4), int'(stream_t[i].vld));
            chk("strm_cnt4l", int'(c4l), int'(stream_t[i].cnt));
            chk("strm_vld4l", int'(v4l), int'(stream_t[i].vld));
            chk("strm_ovr4", int'(o4), 0);
        end
        en = 1'b0;
        step();
        chk("strm_q4_empty", q4.size(), 0);
        chk("strm_q4l_empty", q4l.size(), 0);
        mon4 = 0; mon4l = 0;

        // WIDTH=8 backpressure and overrun
        ready = 1'b0;
        do_reset();
        mon8 = 1;
        byt = 8'hA5;
        for (int k = 7; k >= 0; k--) send(byt[k]);
        q8.push_back(8'hA5);
        chk("w8_vld", int'(v8), 1);
        chk("w8_par", int'(p8), 'hA5);
        chk("w8_ovr0", int'(o8), 0);
        byt = 8'h3C;
        for (int k = 7; k >= 0; k--) begin
            send(byt[k]);
            if (k == 1) chk("w8_ovr_pre", int'(o8), 0);
        end
        chk("w8_ovr1", int'(o8), 1);
        chk("w8_par_hold", int'(p8), 'hA5);
        chk("w8_vld_hold", int'(v8), 1);
        chk("w8_cnt", int'(c8), 0);
        en = 1'b0; ready = 1'b1;
        step();
        chk("w8_vld_drop", int'(v8), 0);
        chk("w8_par_keep", int'(p8), 'hA5);
        chk("w8_ovr_sticky", int'(o8), 1);
        chk("w8_q_empty", q8.size(), 0);
        mon8 = 0;

        // en gaps
        ready = 1'b1;
        do_reset();
        mon4 = 1;
        for (int i = 0; i < 7; i++) begin
            en = tog_t[i].en;
            serial = tog_t[i].ser;
            clear = 1'b0;
            if (i == 6) q4.push_back(8'h0D);
            step();
            chk("tog_cnt", int'(c4), int'(tog_t[i].cnt));
            chk("tog_vld", int'(v4), int'(tog_t[i].vld));
        end
        chk("tog_par", int'(p4), 'hD);
        en = 1'b0;
        step();
        chk("tog_q_empty", q4.size(), 0);

        // clear aborts a partial frame and drops overrun
        ready = 1'b0;
        do_reset();
        send(1); send(0); send(1); send(0);
        q4.push_back(8'h0A);
        send(0); send(0); send(0); send(0);
        chk("clr_ovr_set", int'(o4), 1);
        send(1); send(1);
        chk("clr_cnt_pre", int'(c4), 2);
        en = 1'b1; serial = 1'b1; clear = 1'b1;
        step();
        chk("clr_cnt", int'(c4), 0);
        chk("clr_ovr", int'(o4), 0);
        chk("clr_vld_keep", int'(v4), 1);
        chk("clr_par_keep", int'(p4), 'hA);
        clear = 1'b0; en = 1'b0; ready = 1'b1;
        step();
        chk("clr_consumed", int'(v4), 0);
        send(0); send(1); send(1);
        q4.push_back(8'h06);
        send(0);
        chk("clr_par6", int'(p4), 'h6);
        chk("clr_vld6", int'(v4), 1);
        chk("clr_ovr_after", int'(o4), 0);
        en = 1'b0;
        step();
        chk("clr_q_empty", q4.size(), 0);

        // reset mid-frame with a held word and overrun
        ready = 1'b0;
        do_reset();
        send(1); send(1); send(1); send(1);
        send(0); send(0); send(0); send(0);
        send(1); send(0);
        chk("mr_ovr_pre", int'(o4), 1);
        chk("mr_vld_pre", int'(v4), 1);
        rst = 1'b0; en = 1'b1; serial = 1'b1;
        step();
        chk("mr_par", int'(p4), 0);
        chk("mr_vld", int'(v4), 0);
        chk("mr_ovr", int'(o4), 0);
        chk("mr_cnt", int'(c4), 0);
        rst = 1'b1; ready = 1'b1;
        send(1); send(0); send(0);
        q4.push_back(8'h09);
        send(1);
        chk("mr_par9", int'(p4), 'h9);
        chk("mr_vld9", int'(v4), 1);
        en = 1'b0;
        step();
        chk("mr_q_empty", q4.size(), 0);
        mon4 = 0;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sipo_stream.md
Name: sipo_stream

Overview:
- Parametrised serial-in/parallel-out deserializer; successor to the fixed 4-bit SIPO.
- Collects WIDTH serial bits under an enable and emits each completed word through a one-entry valid/ready output register.
- Adds selectable bit order, a framing counter, a partial-frame clear, and a sticky overrun flag.
- Sits between a bit-serial link front end and word-oriented downstream logic.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = first received bit lands in parallel[WIDTH-1] (MSB-first); 1 = first received bit lands in parallel[0].
- CW, $clog2(WIDTH), localparam; width of bit_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- en  input  1  serial sample enable; serial is sampled on each rising edge with en=1.
- serial  input  1  serial data bit.
- clear  input  1  synchronous abort of the partial frame; also clears overrun.
- ready  input  1  downstream accepts the held word when valid=1 and ready=1.
- parallel  output  WIDTH  held output word.
- valid  output  1  parallel holds an unconsumed word.
- overrun  output  1  sticky; a completed word was dropped.
- bit_count  output  CW  number of bits collected in the current frame, 0..WIDTH-1.

Behaviour:
- Reset (rst=0 at a rising edge) overrides everything. It sets the shift register, bit_count, parallel, valid and overrun to 0.
- Priority per edge: rst, then clear, then en.
- Shift, MSB-first: sr <= {sr[WIDTH-2:0], serial}.
- Shift, LSB-first: sr <= {serial, sr[WIDTH-1:1]}.
- bit_count increments on each accepted bit. At WIDTH-1 with en=1, the frame completes and bit_count wraps to 0.
- Completed word = the shift register contents including the bit sampled at that edge.
- No gaps are required: back-to-back frames continue with no idle cycle.
- en=0: shift register and bit_count hold; serial is ignored.
- clear=1: shift register and bit_count go to 0, overrun goes to 0, and the serial bit that cycle is discarded even if en=1.
- clear does not affect valid or parallel. A held word survives clear.
- Latency: a completed word is visible on parallel with valid=1 in the cycle after the edge that sampled its last bit. That is one edge after completion, with no additional pipeline stage.
- Output register update at each edge, with done = frame completing this edge and fire = valid & ready:
  - done & (!valid | ready): parallel <= word, valid <= 1. Simultaneous consume and load is legal and keeps valid=1 with the new word.
  - done & valid & !ready: word is dropped, parallel and valid hold, overrun <= 1.
  - !done & fire: valid <= 0; parallel holds its last value.
  - Otherwise: hold.
- overrun stays at 1 until reset or clear.
- ready is ignored while valid=0.
- Reset mid-frame discards all partial bits. The next frame starts at bit 0 on the first en edge after rst returns high.
- Asserting clear and completing a frame on the same edge is impossible by priority: clear wins, so no word is produced.

Test Plan:
- WIDTH=4, LSB_FIRST=0, ready=1, en=1, serial repeating 1,1,0,1 for 10 frames -> parallel=4'hD with valid=1 one cycle after every 4th bit. bit_count cycles 0,1,2,3. overrun=0.
- Same stream with LSB_FIRST=1 -> every word = 4'hB.
- WIDTH=8, ready=0, stream 8'hA5 then 8'h3C MSB-first -> parallel=8'hA5 and valid held. overrun=1 at completion of 8'h3C. Then ready=1 for 1 cycle -> valid=0 and parallel still 8'hA5.
- WIDTH=4, en toggled 1,0,0,1,1,0,1 carrying bits 1,1,0,1 on the en=1 edges -> parallel=4'hD. bit_count holds during en=0 cycles.
- WIDTH=4, two bits sent, then clear=1 with en=1 and serial=1 -> bit_count=0. The next four bits 0,1,1,0 -> parallel=4'h6, with no residue from the aborted frame. clear also drops a prior overrun=1 to 0 while valid/parallel keep their held word.
- rst=0 asserted mid-frame with valid=1 and overrun=1 -> on the next edge all outputs are 0. The following frame 1,0,0,1 -> 4'h9.
